// File: rtl/spi_mem_if.sv
// spi_mem_if: SPI slave front end clocked by sck, bridging the serial frame to a
// sync-write/async-read memory. Define SPI_MEM_IF_BURST_EN for address auto-increment.
module spi_mem_if #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 16,
   parameter int MEM_DEPTH = 2**ADDR_W
) (
   input  logic              sck,
   input  logic              rst,
   input  logic              sdi,
   output logic              sdo,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o
);

   localparam int               CNT_MAX   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int               CNT_W     = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]  DEPTH     = (ADDR_W+1)'(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_FETCH,
      S_TX,
      S_RX
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_nxt;
   logic [ADDR_W-1:0] addr_sh;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] rx_word;
   logic              word_last;

   // Address after the current word: increments and wraps in burst mode, held otherwise.
`ifdef SPI_MEM_IF_BURST_EN
   localparam logic [ADDR_W:0]  DEPTH_LAST = (ADDR_W+1)'(MEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   assign addr_nxt = ({1'b0, addr} >= DEPTH_LAST) ? '0 : addr + ADDR_ONE;
`else
   assign addr_nxt = addr;
`endif

   if (ADDR_W > 1) begin : g_addr_sh
      assign addr_sh = {addr[ADDR_W-2:0], sdi};
   end else begin : g_addr_sh1
      assign addr_sh = sdi;
   end

   assign rx_word   = {shreg[DATA_W-2:0], sdi};
   assign word_last = (cnt == DATA_LAST);

   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         state <= S_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      mem_re_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = addr;
      mem_wdata_o = '0;
      case (state)
         S_CMD:   state_nxt = S_ADDR;
         S_ADDR: begin
            if (cnt == ADDR_LAST) begin
               state_nxt = rw ? S_FETCH : S_RX;
            end
         end
         S_FETCH: begin
            mem_re_o  = 1'b1;
            state_nxt = S_TX;
         end
         S_TX: begin
            // Prefetch the next word during the last bit so streaming has no gap.
            if (word_last) begin
               mem_re_o   = 1'b1;
               mem_addr_o = addr_nxt;
            end
         end
         S_RX: begin
            if (word_last) begin
               mem_wdata_o = rx_word;
               mem_we_o    = ({1'b0, addr} < DEPTH);
            end
         end
         default: state_nxt = S_CMD;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         rw    <= 1'b0;
         addr  <= '0;
         cnt   <= '0;
         shreg <= '0;
         sdo   <= 1'b0;
      end else begin
         sdo <= 1'b0;
         case (state)
            S_CMD: begin
               rw  <= sdi;
               cnt <= '0;
            end
            S_ADDR: begin
               addr <= addr_sh;
               cnt  <= (cnt == ADDR_LAST) ? '0 : cnt + CNT_ONE;
            end
            S_FETCH: begin
               shreg <= mem_rdata_i;
               cnt   <= '0;
            end
            S_TX: begin
               sdo <= shreg[DATA_W-1];
               if (word_last) begin
                  shreg <= mem_rdata_i;
                  addr  <= addr_nxt;
                  cnt   <= '0;
               end else begin
                  shreg <= {shreg[DATA_W-2:0], 1'b0};
                  cnt   <= cnt + CNT_ONE;
               end
            end
            S_RX: begin
               shreg <= rx_word;
               if (word_last) begin
                  addr <= addr_nxt;
                  cnt  <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_if.sv
// Self-checking bench for spi_mem_if: full-depth and reduced-depth instances, each with a
// behavioural memory; expected streams and write events come from a frame-level model.
`timescale 1ns/1ps
module tb_spi_mem_if;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 16;
   localparam int DEPTH_A = 32;
   localparam int DEPTH_D = 24;
`ifdef SPI_MEM_IF_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   typedef struct {
      int edge_no;
      int addr;
      int data;
   } ev_t;

   logic              sck = 1'b0;
   logic              rst_a, rst_d, sdi;
   logic              sdo_a, sdo_d;
   logic [ADDR_W-1:0] addr_a, addr_d;
   logic [DATA_W-1:0] rdata_a, rdata_d, wdata_a, wdata_d;
   logic              re_a, re_d, we_a, we_d;

   logic [DATA_W-1:0] mem_a [32];
   logic [DATA_W-1:0] mem_d [32];

   int   checks   = 0;
   int   failures = 0;
   int   overlap  = 0;
   int   edge_no  = 0;
   bit   sel_d    = 1'b0;
   bit   tx_q  [$];
   logic sdo_q [$];
   ev_t  re_log[$];
   ev_t  we_log[$];

   always #5 sck = ~sck;

   assign rdata_a = mem_a[addr_a];
   assign rdata_d = mem_d[addr_d];

   spi_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut_a (
      .sck(sck), .rst(rst_a), .sdi(sdi), .sdo(sdo_a),
      .mem_addr_o(addr_a), .mem_rdata_i(rdata_a), .mem_re_o(re_a),
      .mem_we_o(we_a), .mem_wdata_o(wdata_a)
   );

   spi_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH_D)) dut_d (
      .sck(sck), .rst(rst_d), .sdi(sdi), .sdo(sdo_d),
      .mem_addr_o(addr_d), .mem_rdata_i(rdata_d), .mem_re_o(re_d),
      .mem_we_o(we_d), .mem_wdata_o(wdata_d)
   );

   // Memories commit on the rising edge; strobes of the active instance are logged.
   always @(posedge sck) begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      if (we_d) mem_d[addr_d] <= wdata_d;
      if ((re_a && we_a) || (re_d && we_d)) overlap <= overlap + 1;
      if (sel_d ? re_d : re_a)
         re_log.push_back(ev_t'{edge_no: edge_no, addr: sel_d ? int'(addr_d) : int'(addr_a), data: 0});
      if (sel_d ? we_d : we_a)
         we_log.push_back(ev_t'{edge_no: edge_no, addr: sel_d ? int'(addr_d) : int'(addr_a),
                                data: sel_d ? int'(wdata_d) : int'(wdata_a)});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int nxt(input int a, input int depth);
      if (!BURST) return a;
      return (a + 1 >= depth) ? 0 : a + 1;
   endfunction

   task automatic push_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
   endtask

   // Starts and ends on a falling edge; with stop_high it returns 1 ns after the last rising edge.
   task automatic run_edges(input int n, input bit stop_high);
      for (int i = 0; i < n; i++) begin
         sdi     = (tx_q.size() != 0) ? tx_q.pop_front() : 1'($urandom_range(0, 1));
         edge_no = edge_no + 1;
         @(posedge sck);
         #1;
         sdo_q.push_back(sel_d ? sdo_d : sdo_a);
         if (!(stop_high && i == n - 1)) @(negedge sck);
      end
   endtask

   task automatic start_frame(input bit use_d);
      @(negedge sck);
      sel_d   = use_d;
      edge_no = 0;
      re_log.delete();
      we_log.delete();
      sdo_q.delete();
      tx_q.delete();
      if (use_d) rst_d = 1'b0;
      else       rst_a = 1'b0;
   endtask

   task automatic end_frame();
      rst_a = 1'b1;
      rst_d = 1'b1;
   endtask

   task automatic do_read(input bit use_d, input int addr, input int nwords, input string tag);
      int          depth;
      int          a;
      int          base;
      logic        lead;
      logic [15:0] exp_w, obs_w;
      depth = use_d ? DEPTH_D : DEPTH_A;
      start_frame(use_d);
      tx_q.push_back(1'b1);
      push_bits(addr, ADDR_W);
      run_edges(1 + ADDR_W + 1 + DATA_W * nwords, 1'b0);
      end_frame();
      lead = 1'b0;
      for (int i = 0; i <= ADDR_W + 1; i++) lead = lead | sdo_q[i];
      check($sformatf("%s_sdo_idle", tag), 32'(lead), 32'd0);
      a = addr;
      for (int w = 0; w < nwords; w++) begin
         exp_w = use_d ? mem_d[a] : mem_a[a];
         base  = ADDR_W + 2 + DATA_W * w;
         for (int j = 0; j < DATA_W; j++) obs_w[DATA_W-1-j] = sdo_q[base + j];
         check($sformatf("%s_word%0d", tag, w), 32'(obs_w), 32'(exp_w));
         a = nxt(a, depth);
      end
      check($sformatf("%s_re_count", tag), 32'(re_log.size()), 32'(nwords + 1));
      a = addr;
      for (int k = 0; k <= nwords && k < re_log.size(); k++) begin
         check($sformatf("%s_re%0d_edge", tag, k), 32'(re_log[k].edge_no), 32'(ADDR_W + 2 + DATA_W * k));
         check($sformatf("%s_re%0d_addr", tag, k), 32'(re_log[k].addr), 32'(a));
         a = nxt(a, depth);
      end
      check($sformatf("%s_no_we", tag), 32'(we_log.size()), 32'd0);
   endtask

   task automatic do_write(input bit use_d, input int addr, input logic [15:0] words[$],
                           input string tag);
      int          depth;
      int          a;
      ev_t         exp_ev[$];
      logic [15:0] exp_mem[int];
      depth = use_d ? DEPTH_D : DEPTH_A;
      start_frame(use_d);
      tx_q.push_back(1'b0);
      push_bits(addr, ADDR_W);
      foreach (words[k]) push_bits(32'(words[k]), DATA_W);
      run_edges(1 + ADDR_W + DATA_W * words.size(), 1'b0);
      end_frame();
      a = addr;
      foreach (words[k]) begin
         if (a < depth) begin
            exp_ev.push_back(ev_t'{edge_no: 1 + ADDR_W + DATA_W * (k + 1), addr: a, data: int'(words[k])});
            exp_mem[a] = words[k];
         end
         a = nxt(a, depth);
      end
      check($sformatf("%s_we_count", tag), 32'(we_log.size()), 32'(exp_ev.size()));
      for (int k = 0; k < exp_ev.size() && k < we_log.size(); k++) begin
         check($sformatf("%s_we%0d_edge", tag, k), 32'(we_log[k].edge_no), 32'(exp_ev[k].edge_no));
         check($sformatf("%s_we%0d_addr", tag, k), 32'(we_log[k].addr), 32'(exp_ev[k].addr));
         check($sformatf("%s_we%0d_data", tag, k), 32'(we_log[k].data), 32'(exp_ev[k].data));
      end
      foreach (exp_mem[m])
         check($sformatf("%s_mem%0d", tag, m), 32'(use_d ? mem_d[m] : mem_a[m]), 32'(exp_mem[m]));
      check($sformatf("%s_no_re", tag), 32'(re_log.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] wq[$];
      logic [15:0] keep;
      int          ra;
      rst_a = 1'b1;
      rst_d = 1'b1;
      sdi   = 1'b0;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = 16'($urandom);
         mem_d[i] = 16'($urandom);
      end
      @(negedge sck);

      // Reset values
      check("rst_sdo",   32'(sdo_a),   32'd0);
      check("rst_addr",  32'(addr_a),  32'd0);
      check("rst_re",    32'(re_a),    32'd0);
      check("rst_we",    32'(we_a),    32'd0);
      check("rst_wdata", 32'(wdata_a), 32'd0);

      // Single read and two-word stream
      mem_a[3] = 16'hA5C3;
      mem_a[4] = 16'h1234;
      do_read(1'b0, 3, 1, "single_rd");
      do_read(1'b0, 3, 2, "stream_rd");

      // Burst write across the top of the address space
      wq = '{16'hBEEF, 16'h0001};
      do_write(1'b0, 31, wq, "wr_wrap");

      // Randomized read/write frames
      for (int t = 0; t < 3; t++) begin
         ra = $urandom_range(0, 31);
         wq = '{16'($urandom), 16'($urandom), 16'($urandom)};
         do_write(1'b0, ra, wq, $sformatf("rnd_wr%0d", t));
         do_read(1'b0, $urandom_range(0, 31), 3, $sformatf("rnd_rd%0d", t));
      end

      // Reduced depth: out-of-range write is dropped, reads wrap past the last word
      keep = mem_d[25];
      wq   = '{16'h5555};
      do_write(1'b1, 25, wq, "depth_wr");
      check("depth_mem25_kept", 32'(mem_d[25]), 32'(keep));
      do_read(1'b1, 23, 2, "depth_rd");
      do_read(1'b1, $urandom_range(24, 31), 2, "depth_oor_rd");

      // Abort a write after 9 data bits
      start_frame(1'b0);
      tx_q.push_back(1'b0);
      push_bits(7, ADDR_W);
      run_edges(1 + ADDR_W + 9, 1'b1);
      rst_a = 1'b1;
      #1;
      check("abort_sdo",   32'(sdo_a),   32'd0);
      check("abort_addr",  32'(addr_a),  32'd0);
      check("abort_re",    32'(re_a),    32'd0);
      check("abort_we",    32'(we_a),    32'd0);
      check("abort_wdata", 32'(wdata_a), 32'd0);
      check("abort_no_we", 32'(we_log.size()), 32'd0);
      @(negedge sck);
      do_read(1'b0, $urandom_range(0, 31), 1, "after_abort_rd");

      // Asynchronous reset while sdo is high
      mem_a[3] = 16'hA5C3;
      start_frame(1'b0);
      tx_q.push_back(1'b1);
      push_bits(3, ADDR_W);
      run_edges(ADDR_W + 3, 1'b1);
      check("async_sdo_high", 32'(sdo_a), 32'd1);
      rst_a = 1'b1;
      #1;
      check("async_sdo_low", 32'(sdo_a), 32'd0);
      @(negedge sck);

      check("strobe_overlap", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
